smartlift_ctrl: RTL
===================

# smartlift_ctrl

Parametrised elevator controller for N_FLOORS floors: latches any number of floor requests, serves them in SCAN order (keep direction while requests lie ahead, then reverse), and times floor-to-floor travel and door dwell with internal counters. Sits between the switch/key input stage (debounced, synchronised request strobe) and the board outputs (door LEDs, current-floor seven-segment display). Replaces the single-request, one-floor-per-clock controller.

## Interface
- N_FLOORS, 9, number of floors, 2..10; floors numbered 0..N_FLOORS-1
- TICKS_PER_FLOOR, 50_000_000, MOVE cycles per one-floor step, >=1
- DOOR_TICKS, 100_000_000, cycles the door stays open, >=1
- FW (localparam), $clog2(N_FLOORS), floor index width
- CLOCK_50  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-high
- REQ  in  N_FLOORS  request vector, any bits may be set; sampled only when REQ_STB=1
- REQ_STB  in  1  single-cycle request strobe, already synchronous to CLOCK_50
- FLOOR  out  FW  current floor index
- PENDING  out  N_FLOORS  latched, unserved requests
- MOVING  out  1  car in transit (state MOVE)
- DIR_UP  out  1  current/last travel direction, 1 = up
- LED_G  out  1  door open (state DOOR_OPEN)
- LED_R  out  1  door closed, always ~LED_G
- HEX1  out  7  current floor, seven-segment active-low {g..a}, registered

## Operation
- Reset (async assert, sync release): state IDLE, FLOOR=0, PENDING=0, DIR_UP=1, MOVING=0, LED_G=0, LED_R=1, HEX1=7'b1000000 ("0"), timers 0. RESET mid-move or mid-door aborts immediately; car is considered at floor 0.
- Request latch, every cycle: PENDING <= (PENDING | (REQ_STB ? REQ : 0)) & ~clr. Exception: REQ bit for FLOOR while state is IDLE or DOOR_OPEN is not latched; it opens the door (IDLE) or reloads the door timer (DOOR_OPEN).
- ahead = any PENDING bit strictly beyond FLOOR in DIR_UP direction; behind = any strictly on the other side.
- IDLE: if own-floor request -> DOOR_OPEN, timer=DOOR_TICKS. Else if ahead -> MOVE; else if behind -> toggle DIR_UP, MOVE. Entering MOVE loads timer=TICKS_PER_FLOOR.
- MOVE: decrement timer; at timer==1 FLOOR steps by +-1. If PENDING[new floor]: clear it (clr) same cycle, go DOOR_OPEN with timer=DOOR_TICKS. Else stay MOVE, reload timer. Own-floor requests during MOVE are latched normally.
- DOOR_OPEN: decrement; at timer==1 apply the IDLE direction rule (ahead -> MOVE; behind -> reverse, MOVE; none -> IDLE).
- Simultaneous: arrival clear and REQ_STB for the same floor in one cycle -> bit ends cleared. Request in the reversing direction never preempts an ahead request.
- Bounds: FLOOR never leaves 0..N_FLOORS-1 (moves only toward a pending bit). FLOOR arithmetic in FW bits, no wrap.

## Timing
- REQ_STB at edge t -> PENDING visible after t; MOVING=1 after t+1 (IDLE decision uses registered PENDING).
- Own-floor request in IDLE at t -> LED_G=1 after t.
- Each floor step: exactly TICKS_PER_FLOOR cycles of MOVING=1 per floor; FLOOR and HEX1 update on the same edge.
- LED_G high for exactly DOOR_TICKS cycles (plus reloads); MOVING and LED_G never both 1.
- All outputs registered; no combinational input-to-output path.

## Structure
- Package smartlift_pkg: state enum {IDLE, MOVE, DOOR_OPEN}, seven-segment constants for digits 0..9, blank/"_" pattern.
- Sub-module seg7_dec: FW-bit index -> 7-bit active-low pattern (combinational, registered by parent).
- Timer, ahead/behind reduction and request latch stay in smartlift_ctrl.

## Test plan (N_FLOORS=9, TICKS_PER_FLOOR=4, DOOR_TICKS=3)
- Reset then REQ=9'h020 strobe -> MOVING after 2 cycles, FLOOR 1..5 every 4 cycles, PENDING[5] cleared at arrival, LED_G high 3 cycles, then IDLE.
- At floor 0, strobe REQ bits 2 and 6, while passing floor 3 strobe bit 1 -> stops 2, 6, then reverses (DIR_UP=0) to 1.
- IDLE at floor 4, strobe bit 4 -> no PENDING bit, LED_G=1 next cycle for 3 cycles; second strobe in dwell extends to 3 cycles from that strobe.
- Strobe bit 3 the cycle the car arrives at 3 -> PENDING[3]=0 afterwards, single door cycle.
- RESET asserted mid-MOVE at floor 5 -> outputs at reset values immediately (async), PENDING=0, HEX1=7'b1000000.
- N_FLOORS=2 build: alternating requests 1,0 -> FLOOR toggles, never exceeds 1, DIR_UP flips each trip.

Source files
------------

// File: rtl/smartlift_pkg.sv
// -----------------------------------------------------------------------------
// smartlift_pkg
// Shared types and constants for the SmartLift elevator controller.
//   state_t        : controller state (IDLE, MOVE, DOOR_OPEN)
//   SEG_0..SEG_9   : active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK      : all segments off
//   SEG_UNDERSCORE : only segment d lit
//   max_int()      : elaboration-time helper for sizing the shared timer
// -----------------------------------------------------------------------------
package smartlift_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      DOOR_OPEN
   } state_t;

   localparam logic [6:0] SEG_0          = 7'b1000000;
   localparam logic [6:0] SEG_1          = 7'b1111001;
   localparam logic [6:0] SEG_2          = 7'b0100100;
   localparam logic [6:0] SEG_3          = 7'b0110000;
   localparam logic [6:0] SEG_4          = 7'b0011001;
   localparam logic [6:0] SEG_5          = 7'b0010010;
   localparam logic [6:0] SEG_6          = 7'b0000010;
   localparam logic [6:0] SEG_7          = 7'b1111000;
   localparam logic [6:0] SEG_8          = 7'b0000000;
   localparam logic [6:0] SEG_9          = 7'b0010000;
   localparam logic [6:0] SEG_BLANK      = 7'b1111111;
   localparam logic [6:0] SEG_UNDERSCORE = 7'b1110111;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg7_dec.sv
// -----------------------------------------------------------------------------
// seg7_dec
// Combinational floor-index to seven-segment decoder. The parent registers
// the result, so this block adds no state.
//   idx : floor index, W bits
//   seg : active-low pattern {g,f,e,d,c,b,a}; indices above 9 show blank
// -----------------------------------------------------------------------------
module seg7_dec
   import smartlift_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] idx,
   output logic [6:0]   seg
);

   // NOTE: every output of an always_comb gets a value on every path (here the
   // default arm); a missing assignment would infer a latch.
   always_comb begin
      case (int'(idx))
         0:       seg = SEG_0;
         1:       seg = SEG_1;
         2:       seg = SEG_2;
         3:       seg = SEG_3;
         4:       seg = SEG_4;
         5:       seg = SEG_5;
         6:       seg = SEG_6;
         7:       seg = SEG_7;
         8:       seg = SEG_8;
         9:       seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/smartlift_ctrl.sv
// -----------------------------------------------------------------------------
// smartlift_ctrl
// Multi-request elevator controller. Latches any number of floor requests and
// serves them in SCAN order: keep the travel direction while requests lie
// ahead, reverse only when nothing is left ahead. Floor-to-floor travel and
// door dwell are timed by one shared down-counter.
//   CLOCK_50 : clock, rising edge
//   RESET    : asynchronous, active-high
//   REQ      : request vector, sampled when REQ_STB=1
//   REQ_STB  : single-cycle request strobe (synchronous)
//   FLOOR    : current floor index
//   PENDING  : latched, unserved requests
//   MOVING   : car in transit
//   DIR_UP   : current/last travel direction, 1 = up
//   LED_G    : door open
//   LED_R    : door closed (always ~LED_G)
//   HEX1     : current floor, active-low seven-segment {g..a}
// All outputs are registered.
// -----------------------------------------------------------------------------
module smartlift_ctrl
   import smartlift_pkg::*;
#(
   parameter  int N_FLOORS        = 9,
   parameter  int TICKS_PER_FLOOR = 50_000_000,
   parameter  int DOOR_TICKS      = 100_000_000,
   localparam int FW              = $clog2(N_FLOORS)
) (
   input  logic                CLOCK_50,
   input  logic                RESET,
   input  logic [N_FLOORS-1:0] REQ,
   input  logic                REQ_STB,
   output logic [FW-1:0]       FLOOR,
   output logic [N_FLOORS-1:0] PENDING,
   output logic                MOVING,
   output logic                DIR_UP,
   output logic                LED_G,
   output logic                LED_R,
   output logic [6:0]          HEX1
);

   // One counter serves both the travel and the dwell phases.
   localparam int             TW        = $clog2(max_int(TICKS_PER_FLOOR, DOOR_TICKS) + 1);
   localparam logic [TW-1:0]  MOVE_LOAD = TW'(TICKS_PER_FLOOR);
   localparam logic [TW-1:0]  DOOR_LOAD = TW'(DOOR_TICKS);
   localparam logic [TW-1:0]  TIMER_ONE = TW'(1);

   state_t              state;
   logic [TW-1:0]       timer;

   logic [N_FLOORS-1:0] req_in;      // strobed request vector
   logic [N_FLOORS-1:0] above;       // pending requests strictly above FLOOR
   logic [N_FLOORS-1:0] below;       // pending requests strictly below FLOOR
   logic [N_FLOORS-1:0] own_hot;     // one-hot of FLOOR
   logic [N_FLOORS-1:0] step_hot;    // one-hot of the floor the car steps into
   logic [N_FLOORS-1:0] latch_mask;  // request bits allowed into PENDING
   logic [N_FLOORS-1:0] clr_mask;    // request served on arrival this cycle
   logic [FW-1:0]       floor_step;
   logic [6:0]          seg_step;
   logic                ahead;
   logic                behind;
   logic                go_move;
   logic                reverse;
   logic                door_state;
   logic                own_req;
   logic                step;
   logic                arrive;

   always_comb begin
      req_in     = REQ_STB ? REQ : '0;
      floor_step = DIR_UP ? (FLOOR + FW'(1)) : (FLOOR - FW'(1));
      above      = '0;
      below      = '0;
      own_hot    = '0;
      step_hot   = '0;
      for (int i = 0; i < N_FLOORS; i++) begin
         above[i]    = PENDING[i] && (i > int'(FLOOR));
         below[i]    = PENDING[i] && (i < int'(FLOOR));
         own_hot[i]  = (i == int'(FLOOR));
         step_hot[i] = (i == int'(floor_step));
      end

      // Direction decisions look only at registered PENDING, so a request
      // reaches the car one cycle after it is latched.
      ahead   = DIR_UP ? (|above) : (|below);
      behind  = DIR_UP ? (|below) : (|above);
      go_move = ahead || behind;
      reverse = !ahead && behind;

      // While the car stands at a floor, a request for that floor is served
      // by the door directly and never becomes a pending bit.
      door_state = (state != MOVE);
      own_req    = door_state && (|(req_in & own_hot));
      latch_mask = door_state ? ~own_hot : '1;

      step     = (state == MOVE) && (timer == TIMER_ONE);
      arrive   = step && (|(PENDING & step_hot));
      clr_mask = arrive ? step_hot : '0;
   end

   // Decode the floor being stepped into, so HEX1 and FLOOR change together.
   seg7_dec #(
      .W (FW)
   ) u_seg7_dec (
      .idx (floor_step),
      .seg (seg_step)
   );

   // NOTE: state and outputs are assigned with <= only; blocking assignments
   // in a clocked block create ordering-dependent simulation races.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         timer   <= '0;
         FLOOR   <= '0;
         PENDING <= '0;
         DIR_UP  <= 1'b1;
         MOVING  <= 1'b0;
         LED_G   <= 1'b0;
         LED_R   <= 1'b1;
         HEX1    <= SEG_0;
      end else begin
         // Arrival clear wins over a same-cycle request for that floor.
         PENDING <= (PENDING | (req_in & latch_mask)) & ~clr_mask;

         case (state)
            IDLE: begin
               if (own_req) begin
                  state <= DOOR_OPEN;
                  timer <= DOOR_LOAD;
                  LED_G <= 1'b1;
                  LED_R <= 1'b0;
               end else if (go_move) begin
                  state  <= MOVE;
                  timer  <= MOVE_LOAD;
                  MOVING <= 1'b1;
                  if (reverse) DIR_UP <= ~DIR_UP;
               end
            end

            MOVE: begin
               if (step) begin
                  FLOOR <= floor_step;
                  HEX1  <= seg_step;
                  if (arrive) begin
                     state  <= DOOR_OPEN;
                     timer  <= DOOR_LOAD;
                     MOVING <= 1'b0;
                     LED_G  <= 1'b1;
                     LED_R  <= 1'b0;
                  end else begin
                     timer <= MOVE_LOAD;
                  end
               end else begin
                  timer <= timer - TIMER_ONE;
               end
            end

            DOOR_OPEN: begin
               if (own_req) begin
                  // Someone pressed this floor again: hold the door.
                  timer <= DOOR_LOAD;
               end else if (timer == TIMER_ONE) begin
                  LED_G <= 1'b0;
                  LED_R <= 1'b1;
                  if (go_move) begin
                     state  <= MOVE;
                     timer  <= MOVE_LOAD;
                     MOVING <= 1'b1;
                     if (reverse) DIR_UP <= ~DIR_UP;
                  end else begin
                     state <= IDLE;
                     timer <= '0;
                  end
               end else begin
                  timer <= timer - TIMER_ONE;
               end
            end

            default: begin
               state  <= IDLE;
               timer  <= '0;
               MOVING <= 1'b0;
               LED_G  <= 1'b0;
               LED_R  <= 1'b1;
            end
         endcase
      end
   end

endmodule
